// File: rtl/stream_mux_pkg.sv
// Shared definitions for the round-robin stream multiplexer.
//   state_t    : FSM states (ARB arbitrates every beat, LOCK holds a channel
//                for the remainder of a packet).
//   rr_pick    : round-robin one-hot pick over up to 16 requesters.
//   N_CH_DEF / WIDTH_DEF : default channel count and data width.
package stream_mux_pkg;

  localparam int N_CH_DEF  = 4;
  localparam int WIDTH_DEF = 32;
  localparam int MAX_CH    = 16;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } state_t;

  // Scan ptr+1, ptr+2, ... (mod n) and return the first requester one-hot.
  // Vectors are sized for the widest legal mux; callers zero-extend.
  function automatic logic [MAX_CH-1:0] rr_pick(
    input logic [MAX_CH-1:0] valid,
    input logic [3:0]        ptr,
    input int unsigned       n
  );
    logic [MAX_CH-1:0] pick;
    logic              found;
    int unsigned       idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= MAX_CH; k++) begin
      if (k <= n && !found) begin
        idx = (int'(ptr) + k) % n;
        if (valid[idx[3:0]]) begin
          pick[idx[3:0]] = 1'b1;
          found          = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req   : per-channel request (in_valid)
//   ptr   : index of the most recently served channel
//   grant : one-hot grant, zero when nothing requests
//   idx   : binary index of the granted channel (0 when no grant)
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int N_CH = N_CH_DEF,
  localparam int CH_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] ptr,
  output logic [N_CH-1:0] grant,
  output logic [CH_W-1:0] idx
);

  logic [MAX_CH-1:0] pick_full;
  logic              unused_pick;

  assign pick_full   = rr_pick(MAX_CH'(req), 4'(ptr), N_CH);
  assign grant       = pick_full[N_CH-1:0];
  // Upper bits are always zero for narrower muxes.
  assign unused_pick = ^pick_full;

  always_comb begin
    idx = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant[i]) idx = CH_W'(i);
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with round-robin arbitration and a
// single registered output stage carrying the source channel index.
//   clk, rst (async, active high)
//   in_data/in_valid/in_last/in_ready : N_CH upstream streams
//   out_data/out_last/out_ch/out_valid/out_ready : registered downstream stream
// Optional feature: define STREAM_MUX_PKT_LOCK_EN to keep a channel granted
// from the first beat of a packet until its last beat.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int WIDTH = WIDTH_DEF,
  localparam int CH_W = $clog2(N_CH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_CH-1:0][WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]            in_valid,
  input  logic [N_CH-1:0]            in_last,
  output logic [N_CH-1:0]            in_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_last,
  output logic [CH_W-1:0]            out_ch,
  output logic                       out_valid,
  input  logic                       out_ready
);

  state_t            state_reg, state_next;
  logic [CH_W-1:0]   rr_ptr_reg;
  logic [N_CH-1:0]   arb_grant, grant;
  logic [CH_W-1:0]   arb_idx, sel_idx;
  logic              can_load;
  logic              xfer;
`ifdef STREAM_MUX_PKT_LOCK_EN
  logic [CH_W-1:0]   lock_ch_reg;
`endif

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .req   (in_valid),
    .ptr   (rr_ptr_reg),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  // In LOCK the packet owner is granted even if it is momentarily idle, so
  // nobody else can slip a beat into the middle of the packet.
  always_comb begin
    grant   = arb_grant;
    sel_idx = arb_idx;
    if (state_reg == LOCK) begin
`ifdef STREAM_MUX_PKT_LOCK_EN
      grant              = '0;
      grant[lock_ch_reg] = 1'b1;
      sel_idx            = lock_ch_reg;
`else
      grant              = '0;
`endif
    end
  end

  assign can_load = !out_valid || out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ready
      assign in_ready[gi] = can_load && !rst && grant[gi];
    end
  endgenerate

  assign xfer = |(in_valid & in_ready);

  always_comb begin
    state_next = state_reg;
    if (xfer) begin
`ifdef STREAM_MUX_PKT_LOCK_EN
      state_next = in_last[sel_idx] ? ARB : LOCK;
`else
      state_next = ARB;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ARB;
    end else begin
      state_reg <= state_next;
    end
  end

`ifdef STREAM_MUX_PKT_LOCK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_ch_reg <= '0;
    end else if (xfer) begin
      lock_ch_reg <= sel_idx;
    end
  end
`endif

  // Output register: a new beat may replace the current one in the same
  // cycle it is popped, giving one beat per clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      out_ch     <= '0;
      rr_ptr_reg <= CH_W'(N_CH - 1);
    end else if (xfer) begin
      out_valid  <= 1'b1;
      out_data   <= in_data[sel_idx];
      out_last   <= in_last[sel_idx];
      out_ch     <= sel_idx;
      rr_ptr_reg <= sel_idx;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-channel stream multiplexer and the registered successor to the combinational 4:1 word mux. It accepts N_CH valid/ready input streams of WIDTH bits, picks one with a round-robin arbiter, and drives a single registered valid/ready output with the source channel index attached. It sits wherever several producers share one downstream consumer, such as a bus port, FIFO or serializer.

## Interface
Parameters:
- N_CH, 4, number of input channels; legal values are 2 to 16.
- WIDTH, 32, data width in bits.
- CH_W, $clog2(N_CH), localparam giving the channel index width.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  N_CH×WIDTH  per-channel data, packed as [N_CH-1:0][WIDTH-1:0].
- in_valid  in  N_CH  per-channel valid.
- in_last  in  N_CH  per-channel end-of-packet flag.
- in_ready  out  N_CH  per-channel ready; one-hot or zero.
- out_data  out  WIDTH  registered data.
- out_last  out  1  registered last flag.
- out_ch  out  CH_W  registered source channel index.
- out_valid  out  1  registered valid.
- out_ready  in  1  downstream ready.

## Operation
Reset state (async, while rst is high):
- out_valid=0, out_data=0, out_last=0, out_ch=0.
- Round-robin pointer rr_ptr=N_CH-1.
- FSM=ARB.
- in_ready forced to all zeros.

Output stage:
- One register stage. can_load = !out_valid || out_ready.
- in_ready[i] = can_load && grant[i].
- A transfer on channel g (in_valid[g] && in_ready[g]) loads out_* from channel g and sets out_valid=1 on the next edge.
- out_valid clears when out_ready=1 and no transfer occurs in the same cycle.
- Simultaneous pop and push is supported at full throughput of one beat per clock.

Arbiter (state ARB):
- grant selects the first channel with in_valid=1, scanning rr_ptr+1, rr_ptr+2, … with wrap at N_CH.
- grant is zero when no channel is valid.
- grant is combinational from in_valid and rr_ptr; it never depends on out_ready.
- On each transfer, rr_ptr is set to g.

Stalls:
- While out_valid=1 and out_ready=0, out_* hold stable and every in_ready is 0.

## Timing
- Latency: input beat accepted at edge k appears on out_* after edge k and is valid in cycle k+1.
- Throughput: 1 beat per cycle when out_ready is held at 1.
- Fairness: with all channels continuously valid and the lock feature disabled, grant order after reset is 0,1,2,3,0,…
- A channel that drops in_valid is skipped in the same cycle; there is no bubble.
- Reset mid-packet: outputs clear immediately (asynchronous) and the FSM returns to ARB. The partial packet is lost and the upstream must restart it.

## Configuration
Macro STREAM_MUX_PKT_LOCK_EN.

When defined:
- A second FSM state, LOCK, is added.
- A transfer with in_last[g]=0 moves the FSM to LOCK, latches lock_ch=g and sets rr_ptr=g.
- In LOCK, grant is forced to lock_ch regardless of other valids. If lock_ch's in_valid is low, nothing transfers.
- A transfer with in_last=1 returns the FSM to ARB.
- A single-beat packet (last on the first beat) stays in ARB.

When not defined:
- The FSM is ARB only and arbitration happens every beat.
- Packets from different channels may interleave.
- in_last is carried through to out_last unchanged.

## Structure
- Shared package stream_mux_pkg holds:
  - the FSM state enum: ARB, LOCK.
  - the function rr_pick(valid, ptr), which returns a one-hot grant vector.
  - the default constants N_CH_DEF=4 and WIDTH_DEF=32.
- One sub-module, rr_arbiter (parametrised N_CH): inputs req and ptr, outputs one-hot grant and the encoded index.
- The top level holds the FSM, the output register and the ready logic.

## Test plan
Use defaults N_CH=4, WIDTH=32 with channel data AAAA_AAAA, BBBB_BBBB, CCCC_CCCC, DDDD_DDDD.
- Single channel: after reset, only ch2 is valid with CCCC_CCCC, last=1, out_ready=1 → next cycle out_data=CCCC_CCCC, out_ch=2, out_valid=1.
- Round-robin: all 4 channels valid, out_ready=1, lock disabled → out_ch sequence 0,1,2,3,0 on consecutive cycles, one beat per cycle.
- Backpressure: out_ready=0 for 3 cycles with ch1 holding BBBB_BBBB → out_* stable, in_ready=0000; when out_ready=1, next beat follows with no loss or duplication.
- Skip idle: ch0 and ch3 valid, rr_ptr=0 → grant ch3, then ch0.
- Packet lock (macro defined): ch1 sends a 3-beat packet (last on beat 3) while ch0 is valid → out_ch=1,1,1, then 0; ch0 in_ready stays 0 throughout the packet.
- Async reset: assert rst mid-packet, off the clock edge → out_valid=0 and in_ready=0 immediately; after release the first grant goes to ch0.
